rx_fir_mac_filter: RTL and testbench
====================================

// Module: rx_fir_mac_filter
// PURPOSE
//  Parametrised, time-multiplexed single-MAC FIR filter for the rx chain.
//  Successor to the fixed 512-tap band-pass stage:
//   - taps and widths are parameters; filter is driven by a valid/ready handshake, not a free-running counter
//   - coefficients are loadable at run time; history RAM is zeroed after reset
//   - output uses round-half-up and optional saturation
//  Sits between the rx front-end sample source and the correlator.
// PARAMETERS
//  DATA_W     16  sample width (signed)
//  COEF_W     16  coefficient width (signed)
//  TAPS       512 filter length, power of two, >=4; AW = $clog2(TAPS)
//  OUT_W      16  output width (signed)
//  OUT_SHIFT  10  arithmetic right shift applied to the accumulator before output
//  SAT        1   1: saturate the output to OUT_W; 0: truncate (wrap)
// PORTS
//  crx_clk          in   1       clock
//  rrx_rst_n        in   1       asynchronous, active-low reset
//  erx_en           in   1       enable; low aborts work and returns the FSM to IDLE
//  isample_valid    in   1       input sample valid
//  isample          in   DATA_W  input sample
//  osample_rdy      out  1       block accepts a sample this cycle
//  icoef_we         in   1       coefficient write strobe
//  icoef_addr       in   AW      coefficient index k (multiplies x[n-k])
//  icoef_data       in   COEF_W  coefficient value
//  ocoef_err        out  1       1-cycle pulse: coefficient write ignored (FSM in MAC/DUMP)
//  osample_valid    out  1       1-cycle pulse: ofiltered_sample updated
//  ofiltered_sample out  OUT_W   filtered sample, held until the next update
//  osat             out  1       set with osample_valid when saturation occurred
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all outputs 0; wr_ptr 0; accumulator 0; FSM enters CLEAR
//  CLEAR:
//   - writes 0 to history addresses 0..TAPS-1, one per cycle (TAPS cycles), then goes to IDLE
//   - coefficient RAM is not cleared; it must be loaded before use
//  IDLE:
//   - osample_rdy = 1 only in IDLE with erx_en = 1
//   - accept = isample_valid & osample_rdy
//   - on accept: write isample to hist[wr_ptr], latch base = wr_ptr, wr_ptr <= wr_ptr+1 (mod TAPS), go to MAC
//  MAC (TAPS cycles):
//   - cycle k reads coef[k] and hist[(base-k) mod TAPS]; RAMs have sync read, latency 1
//   - product is registered; acc <= acc + sext(prod) with ACC_W = DATA_W+COEF_W+AW (no internal overflow)
//   - acc is cleared on entry to MAC
//  DUMP (4 cycles):
//   - drains the read/product/accumulate pipeline
//   - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT; the rounding constant is 0 when OUT_SHIFT = 0
//   - SAT=1: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set osat if clamped; SAT=0: r[OUT_W-1:0], osat = 0
//   - on the last DUMP cycle: osample_valid <= 1, ofiltered_sample <= r, FSM goes to IDLE
//  Latency and throughput:
//   - osample_valid rises exactly TAPS+4 cycles after the accept edge
//   - next accept is possible TAPS+5 cycles after the previous one
//  Coefficient writes:
//   - performed in CLEAR or IDLE; a write in the same cycle as accept takes effect for that sample
//   - a write in MAC/DUMP is dropped and ocoef_err pulses the next cycle
//  erx_en low:
//   - in MAC/DUMP: abort with no osample_valid, acc cleared, FSM to IDLE
//   - history and wr_ptr are kept, and the accepted sample stays in history
//   - in CLEAR: CLEAR pauses and resumes when erx_en returns
//  Reset mid-operation: no output is produced; the full CLEAR sequence reruns.
// TESTING (TAPS=8, OUT_SHIFT=0, SAT=1 unless stated)
//  1 Reset then release: osample_rdy stays 0 for 8 cycles, then 1; all outputs 0 throughout.
//  2 coef = 1..8; inputs 1,0,0,...: outputs 1,2,...,8,0 (impulse response); each valid exactly 12 cycles after its accept.
//  3 All coef = 32767, eight inputs of 32767: 8th output = 32767 with osat=1; with all inputs -32768, output = -32768 with osat=1.
//  4 OUT_SHIFT=1, coef[0] = 3, inputs 1 then -1: outputs 2 then -1 (round-half-up).
//  5 isample_valid held high through MAC: only one accept per 13 cycles; a coef write during MAC is dropped, ocoef_err pulses, and the next output is unchanged.
//  6 erx_en low on MAC cycle 3: no osample_valid, returns to IDLE; the next impulse response includes the aborted sample.

Source files
------------

// File: rtl/rx_fir_mac_filter_if.sv
// Sample and coefficient handshake bundle for the rx FIR MAC filter.
// master drives samples/coefficients, slave is the filter.
interface rx_fir_mac_filter_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int AW     = 9,
  parameter int OUT_W  = 16
);
  logic                     isample_valid;
  logic signed [DATA_W-1:0] isample;
  logic                     osample_rdy;
  logic                     icoef_we;
  logic [AW-1:0]            icoef_addr;
  logic signed [COEF_W-1:0] icoef_data;
  logic                     ocoef_err;
  logic                     osample_valid;
  logic signed [OUT_W-1:0]  ofiltered_sample;
  logic                     osat;

  modport master (
    output isample_valid, isample,
    output icoef_we, icoef_addr, icoef_data,
    input  osample_rdy, ocoef_err,
    input  osample_valid, ofiltered_sample, osat
  );

  modport slave (
    input  isample_valid, isample,
    input  icoef_we, icoef_addr, icoef_data,
    output osample_rdy, ocoef_err,
    output osample_valid, ofiltered_sample, osat
  );
endinterface

// File: rtl/rx_fir_mac_filter.sv
// Time-multiplexed single-MAC FIR filter for the rx chain.
// One MAC per tap, sync-read history/coef RAMs, round-half-up output.
module rx_fir_mac_filter #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 512,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 10,
  parameter int SAT       = 1,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic crx_clk,
  input  logic rrx_rst_n,
  input  logic erx_en,
  rx_fir_mac_filter_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic [ACC_W:0] RND =
    ({{ACC_W{1'b0}}, 1'b1} << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] OMAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    MAC,
    DUMP
  } state_t;

  state_t state;

  logic [AW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base;

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];

  logic signed [DATA_W-1:0] hist_q;
  logic signed [COEF_W-1:0] coef_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic                     rd_v;
  logic                     prod_v;

  logic                     accept;
  logic                     coef_ok;
  logic                     hist_we;
  logic [AW-1:0]            hist_wa;
  logic [AW-1:0]            hist_ra;
  logic signed [DATA_W-1:0] hist_wd;

  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_sat;

  assign bus.osample_rdy = (state == IDLE) & erx_en;
  assign accept  = bus.isample_valid & bus.osample_rdy;
  assign coef_ok = (state == CLEAR) | (state == IDLE);
  assign hist_ra = base - cnt;

  always_comb begin
    hist_we = 1'b0;
    hist_wa = wr_ptr;
    hist_wd = bus.isample;
    unique case (1'b1)
      (state == CLEAR) & erx_en: begin
        hist_we = 1'b1;
        hist_wa = cnt;
        hist_wd = '0;
      end
      accept: hist_we = 1'b1;
      default: ;
    endcase
  end

  // RAMs carry no reset; history is zeroed by the CLEAR walk
  always_ff @(posedge crx_clk) begin
    if (hist_we)
      hist[hist_wa] <= hist_wd;
    if (bus.icoef_we & coef_ok)
      coef[bus.icoef_addr] <= bus.icoef_data;
    hist_q <= hist[hist_ra];
    coef_q <= coef[cnt];
  end

  assign rnd_sum = {acc[ACC_W-1], acc} + RND;
  assign shifted = rnd_sum >>> OUT_SHIFT;

  always_comb begin
    r_out = shifted[OUT_W-1:0];
    r_sat = 1'b0;
    if (SAT != 0) begin
      if (shifted > OMAX) begin
        r_out = OMAX[OUT_W-1:0];
        r_sat = 1'b1;
      end else if (shifted < OMIN) begin
        r_out = OMIN[OUT_W-1:0];
        r_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state                <= CLEAR;
      cnt                  <= '0;
      wr_ptr               <= '0;
      base                 <= '0;
      rd_v                 <= 1'b0;
      prod_v               <= 1'b0;
      prod                 <= '0;
      acc                  <= '0;
      bus.osample_valid    <= 1'b0;
      bus.ofiltered_sample <= '0;
      bus.osat             <= 1'b0;
      bus.ocoef_err        <= 1'b0;
    end else begin
      bus.osample_valid <= 1'b0;
      bus.ocoef_err     <= bus.icoef_we & ~coef_ok;
      rd_v              <= (state == MAC) & erx_en;
      prod_v            <= rd_v & erx_en;
      prod              <= coef_q * hist_q;
      if (prod_v & erx_en)
        acc <= acc + {{AW{prod[PROD_W-1]}}, prod};
      unique case (state)
        CLEAR: begin
          if (erx_en) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(TAPS-1)) begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(1);
            cnt    <= '0;
            acc    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          if (!erx_en) begin
            cnt   <= '0;
            acc   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(TAPS-1)) begin
              cnt   <= '0;
              state <= DUMP;
            end
          end
        end
        DUMP: begin
          if (!erx_en) begin
            cnt   <= '0;
            acc   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(3)) begin
              cnt                  <= '0;
              state                <= IDLE;
              bus.osample_valid    <= 1'b1;
              bus.ofiltered_sample <= r_out;
              bus.osat             <= r_sat;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_fir_mac_filter.sv
// Scoreboard bench for rx_fir_mac_filter, TAPS=8.
// u0: OUT_SHIFT=0 with FIR reference model; u1: OUT_SHIFT=1 rounding.
module tb_rx_fir_mac_filter;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;
  localparam int OW   = 16;
  localparam int LAT  = TAPS + 4;

  typedef struct {
    longint val;
    logic   sat;
    int     acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_fir_mac_filter_if #(
    .DATA_W(DW), .COEF_W(CW), .AW(AW), .OUT_W(OW)
  ) b0 ();
  rx_fir_mac_filter_if #(
    .DATA_W(DW), .COEF_W(CW), .AW(AW), .OUT_W(OW)
  ) b1 ();

  rx_fir_mac_filter #(
    .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS),
    .OUT_W(OW), .OUT_SHIFT(0), .SAT(1)
  ) u0 (
    .crx_clk(clk), .rrx_rst_n(rst_n),
    .erx_en(en), .bus(b0)
  );

  rx_fir_mac_filter #(
    .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS),
    .OUT_W(OW), .OUT_SHIFT(1), .SAT(1)
  ) u1 (
    .crx_clk(clk), .rrx_rst_n(rst_n),
    .erx_en(en), .bus(b1)
  );

  int n_chk = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   acc_log[$];

  logic signed [15:0] mcoef [TAPS];
  logic signed [15:0] mhist [TAPS];
  int                 mwp;

  task automatic check(
    input string tag,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // u0: score outputs, then model any accept seen this cycle
  always @(negedge clk) begin
    exp_t   e;
    longint s;
    if (b0.osample_valid) begin
      if (q0.size() == 0) begin
        check("u0_unexp_out", 64'(b0.osample_valid), 0);
      end else begin
        e = q0.pop_front();
        check("u0_out", b0.ofiltered_sample, e.val);
        check("u0_osat", 64'(b0.osat), 64'(e.sat));
        check("u0_lat", cyc - e.acc_cyc, LAT);
      end
    end
    if (b0.isample_valid && b0.osample_rdy) begin
      mhist[mwp] = b0.isample;
      s = 0;
      for (int k = 0; k < TAPS; k++)
        s += longint'(mcoef[k]) *
             longint'(mhist[(mwp - k + TAPS) % TAPS]);
      e.sat = 1'b0;
      if (s > 32767) begin
        s = 32767;
        e.sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        e.sat = 1'b1;
      end
      e.val     = s;
      e.acc_cyc = cyc + 1;
      q0.push_back(e);
      acc_log.push_back(cyc + 1);
      mwp = (mwp + 1) % TAPS;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.osample_valid) begin
      if (q1.size() == 0) begin
        check("u1_unexp_out", 64'(b1.osample_valid), 0);
      end else begin
        e = q1.pop_front();
        check("u1_out", b1.ofiltered_sample, e.val);
        check("u1_osat", 64'(b1.osat), 64'(e.sat));
        check("u1_lat", cyc - e.acc_cyc, LAT);
      end
    end
  end

  task automatic wait_rdy0();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!b0.osample_rdy && t < 100);
    if (!b0.osample_rdy)
      check("u0_rdy_timeout", 64'(b0.osample_rdy), 1);
  endtask

  task automatic send0(input logic signed [15:0] s);
    b0.isample       = s;
    b0.isample_valid = 1'b1;
    wait_rdy0();
    @(posedge clk);
    #1 b0.isample_valid = 1'b0;
  endtask

  task automatic send1(
    input logic signed [15:0] s,
    input longint             want
  );
    exp_t e;
    int   t;
    b1.isample       = s;
    b1.isample_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!b1.osample_rdy && t < 100);
    if (!b1.osample_rdy) begin
      check("u1_rdy_timeout", 64'(b1.osample_rdy), 1);
    end else begin
      e.val     = want;
      e.sat     = 1'b0;
      e.acc_cyc = cyc + 1;
      q1.push_back(e);
    end
    @(posedge clk);
    #1 b1.isample_valid = 1'b0;
  endtask

  task automatic coef_wr0(
    input int                 a,
    input logic signed [15:0] d,
    input bit                 apply
  );
    b0.icoef_we   = 1'b1;
    b0.icoef_addr = AW'(a);
    b0.icoef_data = d;
    if (apply)
      mcoef[a] = d;
    @(posedge clk);
    #1 b0.icoef_we = 1'b0;
  endtask

  task automatic coef_wr1(
    input int                 a,
    input logic signed [15:0] d
  );
    b1.icoef_we   = 1'b1;
    b1.icoef_addr = AW'(a);
    b1.icoef_data = d;
    @(posedge clk);
    #1 b1.icoef_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dump;
    b0.isample_valid = 1'b0;
    b0.isample       = '0;
    b0.icoef_we      = 1'b0;
    b0.icoef_addr    = '0;
    b0.icoef_data    = '0;
    b1.isample_valid = 1'b0;
    b1.isample       = '0;
    b1.icoef_we      = 1'b0;
    b1.icoef_addr    = '0;
    b1.icoef_data    = '0;
    mwp = 0;
    for (int k = 0; k < TAPS; k++) begin
      mhist[k] = '0;
      mcoef[k] = '0;
    end

    // reset state and CLEAR duration
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 64'(b0.osample_rdy), 0);
    check("rst_valid", 64'(b0.osample_valid), 0);
    check("rst_sample", b0.ofiltered_sample, 0);
    check("rst_osat", 64'(b0.osat), 0);
    check("rst_err", 64'(b0.ocoef_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      check("clear_rdy", 64'(b0.osample_rdy), 0);
      check("clear_valid", 64'(b0.osample_valid), 0);
    end
    @(negedge clk);
    check("idle_rdy", 64'(b0.osample_rdy), 1);
    check("u1_idle_rdy", 64'(b1.osample_rdy), 1);
    @(posedge clk);
    #1;

    // impulse response with coef 1..8
    for (int k = 0; k < TAPS; k++)
      coef_wr0(k, 16'(k + 1), 1'b1);
    @(negedge clk);
    check("coef_ok_err", 64'(b0.ocoef_err), 0);
    @(posedge clk);
    #1;
    send0(16'sd1);
    for (int i = 0; i < TAPS; i++)
      send0(16'sd0);
    drain();

    // saturation at both rails
    for (int k = 0; k < TAPS; k++)
      coef_wr0(k, 16'sd32767, 1'b1);
    for (int i = 0; i < TAPS; i++)
      send0(16'sd32767);
    for (int i = 0; i < TAPS; i++)
      send0(-16'sd32768);
    drain();

    // round-half-up on the OUT_SHIFT=1 instance
    for (int k = 0; k < TAPS; k++)
      coef_wr1(k, (k == 0) ? 16'sd3 : 16'sd0);
    send1(16'sd1, 2);
    send1(-16'sd1, -1);
    drain();

    // held valid: throughput and dropped coef write
    for (int k = 0; k < TAPS; k++)
      coef_wr0(k, 16'(k + 1), 1'b1);
    for (int i = 0; i < TAPS; i++)
      send0(16'sd0);
    drain();
    acc_log.delete();
    b0.isample       = 16'sd5;
    b0.isample_valid = 1'b1;
    wait_rdy0();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    coef_wr0(0, 16'sd100, 1'b0);
    @(negedge clk);
    check("coef_err", 64'(b0.ocoef_err), 1);
    @(negedge clk);
    check("coef_err_pulse", 64'(b0.ocoef_err), 0);
    repeat (30) @(posedge clk);
    #1 b0.isample_valid = 1'b0;
    check("hold_accepts", acc_log.size(), 3);
    for (int i = 1; i < acc_log.size(); i++)
      check("accept_gap", acc_log[i] - acc_log[i-1], TAPS + 5);
    drain();

    // abort on MAC cycle 3, sample stays in history
    for (int i = 0; i < TAPS; i++)
      send0(16'sd0);
    drain();
    b0.isample       = 16'sd1;
    b0.isample_valid = 1'b1;
    wait_rdy0();
    @(posedge clk);
    #1 b0.isample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 en = 1'b1;
    if (q0.size() != 0)
      dump = q0.pop_back();
    @(negedge clk);
    check("abort_idle", 64'(b0.osample_rdy), 1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    send0(16'sd0);
    send0(16'sd0);
    drain();

    check("final_q0", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
